// File: rtl/defuzz_sched.sv
// defuzz_sched
// Shares one sequential defuzzification divider among N_CH requesters.
// A round-robin arbiter grants one requester at a time. Its Q1.15 pair
// (S_w, S_wg) is captured, the quotient (S_wg << 15) / S_w is formed by a
// 32-step restoring divider, and the quotient is scaled to a rounded
// percentage saturated at 100. The result is bit-exact with the
// single-cycle defuzzifier formula.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous abort of any in-flight operation
//   req          per-channel level request
//   s_w_flat     channel k S_w at [16k+15:16k]
//   s_wg_flat    channel k S_wg at [16k+15:16k]
//   ack          one-hot 1-cycle pulse: operands of that channel captured
//   busy         high while an operation is in flight
//   res_valid    1-cycle pulse: G_out / res_id valid
//   res_id       channel of the current result
//   G_out        result percent 0..100
//   G_hold_flat  (only with DEFUZZ_SCHED_HOLD_EN) last result per channel
//
// Optional feature macro: DEFUZZ_SCHED_HOLD_EN
module defuzz_sched #(
    parameter int N_CH = 4,
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [N_CH-1:0]    req,
    input  logic [16*N_CH-1:0] s_w_flat,
    input  logic [16*N_CH-1:0] s_wg_flat,
    output logic [N_CH-1:0]    ack,
    output logic               busy,
    output logic               res_valid,
    output logic [ID_W-1:0]    res_id,
    output logic [7:0]         G_out
`ifdef DEFUZZ_SCHED_HOLD_EN
    ,
    output logic [8*N_CH-1:0]  G_hold_flat
`endif
);

    typedef enum logic [1:0] {IDLE, DIV, SCALE} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id;
    logic [15:0]     den;
    logic [31:0]     dividend;
    logic [16:0]     rem;
    logic [31:0]     q;
    logic [4:0]      cnt;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    int              idx;
    logic            accept;
    logic [15:0]     sel_sw;
    logic [15:0]     sel_swg;
    logic [16:0]     rem_sh;
    logic            ge;
    logic [16:0]     rem_nx;
    logic [31:0]     prod;
    logic [31:0]     pct;

    function automatic logic [7:0] sat_pct(input logic [31:0] p);
        return (p > 32'd100) ? 8'd100 : p[7:0];
    endfunction

    // Round-robin search: first set request at or after ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(ptr) + i) % N_CH;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx[ID_W-1:0];
            end
        end
    end

    assign accept  = (state == IDLE) && !flush && grant_found;
    assign sel_sw  = s_w_flat[16*grant_id +: 16];
    assign sel_swg = s_wg_flat[16*grant_id +: 16];

    // Restoring division step. The remainder is always below den after a
    // step, so its top bit is zero and may be dropped by the shift.
    assign rem_sh = 17'({rem, dividend[31]});
    assign ge     = (rem_sh >= {1'b0, den});
    assign rem_nx = ge ? (rem_sh - {1'b0, den}) : rem_sh;

    // Percent scaling with round-half-up; the product wraps at 32 bits
    // exactly like the reference single-cycle formula.
    assign prod = q * 32'd100;
    assign pct  = (prod + 32'd16384) >> 15;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = DIV;
            DIV: begin
                if (flush)             state_nx = IDLE;
                else if (cnt == 5'd31) state_nx = SCALE;
            end
            SCALE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ack       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            G_out     <= 8'd0;
            ptr       <= '0;
            id        <= '0;
            den       <= 16'd0;
            dividend  <= 32'd0;
            rem       <= 17'd0;
            q         <= 32'd0;
            cnt       <= 5'd0;
        end else begin
            state     <= state_nx;
            busy      <= (state_nx != IDLE);
            ack       <= '0;
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ack      <= {{(N_CH-1){1'b0}}, 1'b1} << grant_id;
                        ptr      <= (int'(grant_id) == N_CH - 1) ? '0 : grant_id + 1'b1;
                        id       <= grant_id;
                        den      <= (sel_sw == 16'd0) ? 16'd1 : sel_sw;
                        dividend <= {1'b0, sel_swg, 15'd0};
                        rem      <= 17'd0;
                        q        <= 32'd0;
                        cnt      <= 5'd0;
                    end
                end
                DIV: begin
                    if (!flush) begin
                        rem      <= rem_nx;
                        q        <= {q[30:0], ge};
                        dividend <= {dividend[30:0], 1'b0};
                        cnt      <= cnt + 5'd1;
                    end
                end
                SCALE: begin
                    if (!flush) begin
                        G_out     <= sat_pct(pct);
                        res_id    <= id;
                        res_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEFUZZ_SCHED_HOLD_EN
    // Per-channel copy of the most recent result; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            G_hold_flat <= '0;
        end else if (res_valid) begin
            G_hold_flat[8*res_id +: 8] <= G_out;
        end
    end
`endif

endmodule

// File: tb/tb_defuzz_sched.sv
// tb_defuzz_sched
// Directed bench for defuzz_sched (N_CH=4): single-channel results,
// round-robin ordering and spacing, flush mid-division, async reset
// mid-division. Expected values are hand-computed constants.
module tb_defuzz_sched;

    localparam int N_CH = 4;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic [N_CH-1:0]    req;
    logic [16*N_CH-1:0] s_w_flat;
    logic [16*N_CH-1:0] s_wg_flat;
    logic [N_CH-1:0]    ack;
    logic               busy;
    logic               res_valid;
    logic [1:0]         res_id;
    logic [7:0]         G_out;
`ifdef DEFUZZ_SCHED_HOLD_EN
    logic [8*N_CH-1:0]  G_hold_flat;
`endif

    defuzz_sched #(.N_CH(N_CH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req        (req),
        .s_w_flat   (s_w_flat),
        .s_wg_flat  (s_wg_flat),
        .ack        (ack),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .G_out      (G_out)
`ifdef DEFUZZ_SCHED_HOLD_EN
        ,
        .G_hold_flat(G_hold_flat)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Operand table and hand-computed percentages:
    //  ch0 0x4000/0x8000 -> q=16384  -> 50
    //  ch1 0x0003/0x0008 -> q=12288  -> 38 (37.5 rounds up)
    //  ch2 0x0001/den=1  -> q=32768  -> 100
    //  ch3 0x7FFF/0x0100 -> saturates -> 100
    logic [15:0] tab_sw  [N_CH] = '{16'h8000, 16'h0008, 16'h0000, 16'h0100};
    logic [15:0] tab_swg [N_CH] = '{16'h4000, 16'h0003, 16'h0001, 16'h7FFF};
    int          exp_g   [N_CH] = '{50, 38, 100, 100};

    int last_g;
    int last_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ack(output int k, output int c);
        k = -1;
        c = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                for (int j = 0; j < N_CH; j++) if (ack[j]) k = j;
                c = cyc;
                return;
            end
        end
        chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_res(output int c);
        c = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid) begin
                c = cyc;
                return;
            end
        end
        chk("res_timeout", 0, 1);
    endtask

    task automatic run_single(input int ch);
        int k, ca, cr;
        req = '0;
        req[ch] = 1'b1;
        wait_ack(k, ca);
        req = '0;
        chk("single_ack_ch", k, ch);
        chk("single_busy_hi", int'(busy), 1);
        wait_res(cr);
        chk("single_latency", cr - ca, 33);
        chk("single_res_id", int'(res_id), ch);
        chk("single_G", int'(G_out), exp_g[ch]);
        chk("single_busy_lo", int'(busy), 0);
        last_g  = int'(G_out);
        last_id = int'(res_id);
    endtask

    // Accept ch0, flush during the DIV step with cnt==10, then expect the
    // next grant to go to exp_ch with req_after applied.
    task automatic flush_case(input logic [N_CH-1:0] req_after, input int exp_ch);
        int k, ca, cr;
        req = 4'b0001;
        wait_ack(k, ca);
        chk("flush_ack_ch0", k, 0);
        req = req_after;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("flush_no_res_pre", int'(res_valid), 0);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy_lo", int'(busy), 0);
        chk("flush_no_res", int'(res_valid), 0);
        chk("flush_G_hold", int'(G_out), last_g);
        chk("flush_id_hold", int'(res_id), last_id);
        wait_ack(k, ca);
        req = '0;
        chk("flush_next_grant", k, exp_ch);
        wait_res(cr);
        chk("flush_next_id", int'(res_id), exp_ch);
        chk("flush_next_G", int'(G_out), exp_g[exp_ch]);
        last_g  = int'(G_out);
        last_id = int'(res_id);
    endtask

    initial begin
        int k, ca, cr, prev;
        int rr_exp [5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        flush = 1'b0;
        req   = '0;
        for (int i = 0; i < N_CH; i++) begin
            s_w_flat[16*i +: 16]  = tab_sw[i];
            s_wg_flat[16*i +: 16] = tab_swg[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_id", int'(res_id), 0);
        chk("rst_G", int'(G_out), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int ch = 0; ch < N_CH; ch++) run_single(ch);

`ifdef DEFUZZ_SCHED_HOLD_EN
        @(negedge clk);
        chk("hold_flat", int'(G_hold_flat), int'({8'd100, 8'd100, 8'd38, 8'd50}));
`endif

        // All requests held: pointer is back at 0 after ch3.
        req  = 4'b1111;
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_ack(k, ca);
            if (i == 4) req = '0;
            chk("rr_ack_order", k, rr_exp[i]);
            if (i > 0) chk("rr_ack_gap", ca - prev, 34);
            chk("rr_busy_hi", int'(busy), 1);
            prev = ca;
            wait_res(cr);
            chk("rr_res_id", int'(res_id), rr_exp[i]);
            chk("rr_G", int'(G_out), exp_g[rr_exp[i]]);
            chk("rr_busy_gap", int'(busy), 0);
        end
        last_g  = int'(G_out);
        last_id = int'(res_id);

        // Pointer is 1 after the last ch0 grant.
        flush_case(4'b0011, 1);
        // Pointer is 2 after ch1; ch0 alone wins, then with req[1]=0 ch0 again.
        flush_case(4'b0001, 0);

        // Async reset in the middle of a division.
        req = 4'b0001;
        wait_ack(k, ca);
        req = '0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ack", int'(ack), 0);
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_res_id", int'(res_id), 0);
        chk("arst_G", int'(G_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("arst_abandoned", int'(res_valid), 0);
        end

        // Pointer cleared by reset: ch0 wins among all requests.
        req = 4'b1111;
        wait_ack(k, ca);
        req = '0;
        chk("arst_ptr_grant", k, 0);
        wait_res(cr);
        chk("arst_post_G", int'(G_out), 50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/defuzz_sched.md
Name: defuzz_sched

Overview:
- Shares one sequential defuzzification divider among N_CH requesters, e.g. per-zone rule-aggregation engines.
- Each requester presents an (S_w, S_wg) Q1.15 pair.
- The block arbitrates round-robin, runs a 1-bit-per-cycle restoring division, scales to percent and returns G (0..100) tagged with the channel ID.
- Arithmetic is bit-exact with the team's single-cycle defuzzifier formula; it trades latency for area.

Parameters:
- N_CH, 4, number of requesters (2..16); ID_W = $clog2(N_CH) is derived as a localparam.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous abort of any in-flight operation
- req  in  N_CH  per-channel request, level
- s_w_flat  in  16*N_CH  channel k S_w (Q1.15) at [16k+15:16k]
- s_wg_flat  in  16*N_CH  channel k S_wg (Q1.15) at [16k+15:16k]
- ack  out  N_CH  one-hot, 1-cycle pulse: operands of that channel captured
- busy  out  1  high while not IDLE
- res_valid  out  1  1-cycle pulse: G_out/res_id valid
- res_id  out  ID_W  channel of current result
- G_out  out  8  result percent 0..100

Behaviour:
- Reset (async): state IDLE; ack=0, busy=0, res_valid=0, res_id=0, G_out=0; RR pointer=0; divider regs=0.
- Reset mid-operation abandons the op silently: no result, no ack.
- States: IDLE, DIV, SCALE.
- IDLE:
  - If flush=1: stay IDLE, no grant.
  - Else if any req: grant the first set bit at or after the pointer, wrapping.
  - On that edge: pulse ack[k], capture S_w/S_wg of k, latch id, set pointer=(k+1) mod N_CH, go DIV.
- Operand capture:
  - den = (S_w==0) ? 1 : S_w.
  - dividend = {16'd0,S_wg}<<15, 32 bits.
  - remainder=0, quotient=0, cnt=0.
- DIV: one restoring-division step per cycle, MSB first, 32 steps.
  - rem = {rem,dividend_bit} (17 bits); if rem>=den: rem-=den, q bit=1.
  - After step 32 (cnt==31), go SCALE.
- SCALE (1 cycle):
  - p = (q*100 + 16384)>>15, 32-bit arithmetic.
  - G_out <= (p>100) ? 100 : p[7:0]; res_id <= latched id; res_valid=1 for one cycle; go IDLE.
- Timing:
  - Accept edge = edge 0; res_valid is high in the cycle after edge 33.
  - The next accept can occur at edge 34 (in IDLE), so throughput is 1 op / 34 cycles.
- ack fires only at accept.
- Requester handshake:
  - Holds req and operands until its ack.
  - Deasserts or keeps req after ack as it chooses.
  - req still high at the next IDLE is a new request.
- Dropping req before ack: legal, no effect.
- Operand changes after ack do not affect the in-flight op.
- busy = (state != IDLE), registered with the state.
- flush in DIV or SCALE:
  - Next state IDLE, res_valid suppressed.
  - G_out/res_id keep their previous values.
  - RR pointer keeps its post-grant value.
- flush and req together in IDLE: flush wins.
- G_out/res_id hold until the next SCALE.

Optional Feature:
- Macro DEFUZZ_SCHED_HOLD_EN.
- Defined: extra output G_hold_flat [8*N_CH].
  - Per-channel register, updated with G_out on res_valid for that res_id.
  - Reset 0; flush does not clear it.
- Undefined: port and registers absent; behaviour otherwise identical.

Test Plan:
- ch0 only, S_wg=0x4000, S_w=0x8000 -> ack[0] at edge 0; res_valid after edge 33, res_id=0, G_out=50.
- ch1, S_wg=0x0003, S_w=0x0008 -> G_out=38 (37.5 rounds up).
- ch2, S_w=0x0000, S_wg=0x0001 -> den=1, G_out=100.
- ch3, S_wg=0x7FFF, S_w=0x0100 -> G_out=100 (saturation).
- All four req held high from reset:
  - ack order 0,1,2,3,0, acks 34 cycles apart.
  - res_id sequence matches.
  - busy low exactly one cycle between ops.
- ch0 accepted, flush at DIV cnt=10 -> no res_valid, busy=0 next cycle.
  - Next grant goes to ch1 if req[1]=1, else ch0.
  - Async rst_n low mid-DIV -> all outputs 0 immediately.
